gpr_cdb_arbiter: RTL and testbench
==================================

Name: gpr_cdb_arbiter

Overview:
- Sits directly downstream of the GPR-writing reservation stations (mov, alu, fpu-to-gpr, load).
- Arbitrates their gpr_cdb_req handshakes: at most one grant per cycle, round-robin.
- Next cycle, muxes the granted unit's registered result onto the shared GPR common data bus (valid/tag/data), which the reservation stations, GPR file and ROB snoop.
- Supports a flush on branch mispredict.

Parameters:
- N_REQ, 4, number of requesting units (2..8); requester 0 is the mov unit.
- ROB_WIDTH, 4, tag width, matches the common header value.
- DATA_W, 32, result data width.

Ports:
- clk  in  1  single clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  N_REQ  per-unit gpr_cdb_req.valid.
- req_ready  out  N_REQ  per-unit gpr_cdb_req.ready (grant).
- unit_tag  in  N_REQ x ROB_WIDTH  per-unit registered result tag, meaningful the cycle after its grant.
- unit_data  in  N_REQ x DATA_W  per-unit registered result data, same timing.
- flush  in  1  mispredict flush, kills grants and pending broadcast.
- cdb_valid  out  1  GPR CDB broadcast valid.
- cdb_tag  out  ROB_WIDTH  broadcast ROB tag.
- cdb_data  out  DATA_W  broadcast data.
- bcast_count  out  32  number of broadcasts since reset, wraps.

Behaviour:
State:
- rr_ptr: $clog2(N_REQ) bits, highest-priority requester.
- sel_valid, sel_id: broadcast pending for the next cycle.
- bcast_count.

Reset:
- All state and outputs are cleared asynchronously while reset=0: rr_ptr=0, sel_valid=0, sel_id=0, bcast_count=0.
- Outputs during reset: req_ready=0, cdb_valid=0, cdb_tag=0, cdb_data=0.
- Release is sampled on a clock edge. The first grant is possible in the first cycle with reset=1.

Grant (combinational, cycle t):
- Scan requesters starting at rr_ptr, upward, modulo N_REQ.
- The first i with req_valid[i]=1 gets req_ready[i]=1. All other req_ready bits are 0.
- req_ready[i] is asserted only when req_valid[i]=1, never otherwise.
- If flush=1, all req_ready are 0.
- No dependence on any unit's readiness beyond req_valid: no combinational loop through req_ready→req_valid is allowed in units.

Sequential update at the end of cycle t:
- On a grant to i: sel_valid<=1, sel_id<=i, rr_ptr<=(i+1) mod N_REQ.
- With no grant or with flush: sel_valid<=0, rr_ptr unchanged.

Broadcast (cycle t+1, combinational from registered select):
- cdb_valid = sel_valid && !flush.
- cdb_tag = unit_tag[sel_id] and cdb_data = unit_data[sel_id] when cdb_valid, else 0.
- Latency: grant to bus is exactly 1 cycle. Throughput is 1 broadcast per cycle. Back-to-back grants to the same or different units are legal.

Counter:
- bcast_count increments by 1 on every cycle with cdb_valid=1, wrapping at 2^32.

Boundary and simultaneous-event rules:
- All requesters valid: strict rotation, each unit granted once per N_REQ cycles.
- Single requester valid continuously: granted every cycle. rr_ptr walks past it but the scan still finds it.
- flush in cycle t while a broadcast is pending: that broadcast is suppressed (cdb_valid=0) and not counted. A grant made in t-1 is still cleared.
- flush held multiple cycles: no grants, no broadcasts.
- Reset asserted mid-operation: a pending broadcast is dropped immediately. Units must also reset.
- rr_ptr wrap: grant to N_REQ-1 sets rr_ptr=0.

Test Plan:
1. Reset with all req_valid=1, then release → cycle 0 grants unit 0. Cycle 1: cdb_valid=1 with unit 0's tag/data (e.g. tag 4'h3, data 32'h0000_1234). Grant order 0,1,2,3,0.
2. Only unit 2 valid for 5 cycles with tags 1..5 → req_ready[2]=1 every cycle. The CDB shows tags 1..5 on consecutive cycles, each one cycle after its grant. bcast_count=5.
3. Units 1 and 3 valid, rr_ptr=2 → unit 3 is granted first, then unit 1. The next simultaneous request after that goes to unit 3.
4. Grant to unit 1 (tag 4'h7), flush=1 the next cycle → cdb_valid=0, bcast_count unchanged, all req_ready=0 during the flush.
5. Assert reset asynchronously mid-cycle with sel_valid=1 → cdb_valid drops to 0 without waiting for a clock edge. After release, rr_ptr=0 and bcast_count=0.
6. mov unit integration: mov entry waiting on tag 4'h5 while unit 2 broadcasts tag 5, data 32'hDEAD_BEEF → mov requests next cycle, is granted, and broadcasts its own tag with data 32'hDEAD_BEEF one cycle later.

Source files
------------

// File: rtl/gpr_cdb_arbiter_if.sv
// Handshake and broadcast bundle between the GPR-writing reservation stations
// and the GPR common data bus arbiter.
interface gpr_cdb_arbiter_if #(
  parameter int N_REQ     = 4,
  parameter int ROB_WIDTH = 4,
  parameter int DATA_W    = 32
);
  logic [N_REQ-1:0]                req_valid;
  logic [N_REQ-1:0]                req_ready;
  logic [N_REQ-1:0][ROB_WIDTH-1:0] unit_tag;
  logic [N_REQ-1:0][DATA_W-1:0]    unit_data;
  logic                            flush;
  logic                            cdb_valid;
  logic [ROB_WIDTH-1:0]            cdb_tag;
  logic [DATA_W-1:0]               cdb_data;
  logic [31:0]                     bcast_count;

  // Requesting side: the reservation stations (or a bench standing in for them).
  modport master (
    output req_valid, unit_tag, unit_data, flush,
    input  req_ready, cdb_valid, cdb_tag, cdb_data, bcast_count
  );

  modport slave (
    input  req_valid, unit_tag, unit_data, flush,
    output req_ready, cdb_valid, cdb_tag, cdb_data, bcast_count
  );
endinterface

// File: rtl/gpr_cdb_arbiter.sv
// Round-robin arbiter for the GPR common data bus: one grant per cycle, the
// granted unit's registered result is broadcast the following cycle.
module gpr_cdb_arbiter #(
  parameter int N_REQ     = 4,
  parameter int ROB_WIDTH = 4,
  parameter int DATA_W    = 32
) (
  input logic              clk,
  input logic              reset,
  gpr_cdb_arbiter_if.slave bus
);
  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0] sel_id_q, sel_id_d;
  logic             sel_valid_q, sel_valid_d;
  logic [31:0]      bcast_count_q, bcast_count_d;

  logic [N_REQ-1:0] grant;
  logic             grant_found;
  logic [PTR_W-1:0] grant_id;
  logic [PTR_W-1:0] scan_idx;
  logic             cdb_valid;

  function automatic logic [PTR_W-1:0] wrap_idx(input int base, input int off);
    return PTR_W'((base + off) % N_REQ);
  endfunction

  // Grant is gated by reset so req_ready stays low while the block is held in reset.
  always_comb begin
    grant       = '0;
    grant_found = 1'b0;
    grant_id    = '0;
    scan_idx    = '0;
    if (reset && !bus.flush) begin
      for (int k = 0; k < N_REQ; k++) begin
        scan_idx = wrap_idx(int'(rr_ptr_q), k);
        if (!grant_found && bus.req_valid[scan_idx]) begin
          grant_found      = 1'b1;
          grant_id         = scan_idx;
          grant[scan_idx]  = 1'b1;
        end
      end
    end
  end

  always_comb begin
    sel_valid_d   = grant_found;
    sel_id_d      = grant_found ? grant_id : sel_id_q;
    rr_ptr_d      = rr_ptr_q;
    if (grant_found) begin
      rr_ptr_d = (grant_id == PTR_W'(N_REQ - 1)) ? '0 : grant_id + PTR_W'(1);
    end
    bcast_count_d = bcast_count_q + 32'(cdb_valid);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr_q      <= '0;
      sel_id_q      <= '0;
      sel_valid_q   <= 1'b0;
      bcast_count_q <= '0;
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      sel_id_q      <= sel_id_d;
      sel_valid_q   <= sel_valid_d;
      bcast_count_q <= bcast_count_d;
    end
  end

  // A flush arriving in the broadcast cycle kills the pending result outright.
  assign cdb_valid       = sel_valid_q && !bus.flush;
  assign bus.req_ready   = grant;
  assign bus.cdb_valid   = cdb_valid;
  assign bus.cdb_tag     = cdb_valid ? bus.unit_tag[sel_id_q]  : '0;
  assign bus.cdb_data    = cdb_valid ? bus.unit_data[sel_id_q] : '0;
  assign bus.bcast_count = bcast_count_q;
endmodule

// File: tb/tb_gpr_cdb_arbiter.sv
// Directed bench for gpr_cdb_arbiter: a reference round-robin model predicts
// grants, and granted unit ids are queued until their broadcast cycle.
module tb_gpr_cdb_arbiter;
  localparam int N  = 4;
  localparam int RW = 4;
  localparam int DW = 32;

  logic clk;
  logic reset;

  gpr_cdb_arbiter_if #(.N_REQ(N), .ROB_WIDTH(RW), .DATA_W(DW)) bus ();

  gpr_cdb_arbiter #(.N_REQ(N), .ROB_WIDTH(RW), .DATA_W(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int          m_rr;
  int unsigned m_cnt;
  int          sb[$];

  // Registered results each unit presents this cycle
  logic [RW-1:0] u_tag  [N];
  logic [DW-1:0] u_data [N];

  // Last observed values from step()
  logic [N-1:0]  obs_ready;
  logic          obs_valid;
  logic [RW-1:0] obs_tag;
  logic [DW-1:0] obs_data;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic drive_units();
    for (int i = 0; i < N; i++) begin
      bus.unit_tag[i]  = u_tag[i];
      bus.unit_data[i] = u_data[i];
    end
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic step(input logic [N-1:0] rv, input logic fl);
    logic [N-1:0]  exp_ready;
    logic          exp_v;
    logic [RW-1:0] exp_tag;
    logic [DW-1:0] exp_data;
    int            g;
    int            id;
    bus.req_valid = rv;
    bus.flush     = fl;
    drive_units();
    #1;
    exp_ready = '0;
    g = -1;
    if (!fl) begin
      for (int k = 0; k < N; k++) begin
        if (g < 0 && rv[(m_rr + k) % N]) g = (m_rr + k) % N;
      end
    end
    if (g >= 0) exp_ready[g] = 1'b1;
    chk("req_ready", 64'(bus.req_ready), 64'(exp_ready));

    exp_v = 1'b0; exp_tag = '0; exp_data = '0;
    if (sb.size() > 0) begin
      id = sb.pop_front();
      if (!fl) begin
        exp_v    = 1'b1;
        exp_tag  = u_tag[id];
        exp_data = u_data[id];
      end
    end
    chk("cdb_valid",   64'(bus.cdb_valid),   64'(exp_v));
    chk("cdb_tag",     64'(bus.cdb_tag),     64'(exp_tag));
    chk("cdb_data",    64'(bus.cdb_data),    64'(exp_data));
    chk("bcast_count", 64'(bus.bcast_count), 64'(m_cnt));

    obs_ready = bus.req_ready;
    obs_valid = bus.cdb_valid;
    obs_tag   = bus.cdb_tag;
    obs_data  = bus.cdb_data;

    if (exp_v) m_cnt++;
    if (g >= 0) begin
      sb.push_back(g);
      m_rr = (g + 1) % N;
    end
    @(negedge clk);
  endtask

  task automatic model_reset();
    sb.delete();
    m_rr  = 0;
    m_cnt = 0;
  endtask

  task automatic do_reset(input logic [N-1:0] rv);
    reset         = 1'b0;
    bus.req_valid = rv;
    bus.flush     = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("rst_req_ready",   64'(bus.req_ready),   64'd0);
    chk("rst_cdb_valid",   64'(bus.cdb_valid),   64'd0);
    chk("rst_cdb_tag",     64'(bus.cdb_tag),     64'd0);
    chk("rst_cdb_data",    64'(bus.cdb_data),    64'd0);
    chk("rst_bcast_count", 64'(bus.bcast_count), 64'd0);
    reset = 1'b1;
  endtask

  logic [DW-1:0]   mov_data;
  logic            mov_req;
  int unsigned     saved_cnt;
  logic [N*N-1:0]  grant_seq;

  initial begin
    for (int i = 0; i < N; i++) begin
      u_tag[i]  = RW'(i + 3);
      u_data[i] = DW'(32'h0000_1234 + 32'h1000 * i);
    end
    bus.req_valid = '0;
    bus.flush     = 1'b0;
    drive_units();
    reset = 1'b1;
    #2;

    // 1: all requesters valid through reset; strict rotation 0,1,2,3,0
    do_reset('1);
    step('1, 1'b0);
    chk("t1_first_grant", 64'(obs_ready), 64'b0001);
    step('1, 1'b0);
    chk("t1_tag_unit0",  64'(obs_tag),  64'h3);
    chk("t1_data_unit0", 64'(obs_data), 64'h0000_1234);
    chk("t1_grant1", 64'(obs_ready), 64'b0010);
    step('1, 1'b0);
    chk("t1_grant2", 64'(obs_ready), 64'b0100);
    step('1, 1'b0);
    chk("t1_grant3", 64'(obs_ready), 64'b1000);
    step('1, 1'b0);
    chk("t1_grant0_again", 64'(obs_ready), 64'b0001);
    step('0, 1'b0);

    // 2: only unit 2 valid for 5 cycles, tags 1..5 one cycle after each grant
    do_reset('0);
    for (int k = 0; k < 6; k++) begin
      u_tag[2]  = RW'(k);
      u_data[2] = DW'(32'hA000_0000 + k);
      step((k < 5) ? 4'b0100 : 4'b0000, 1'b0);
      if (k < 5) chk("t2_ready2", 64'(obs_ready), 64'b0100);
      if (k > 0) chk("t2_tag", 64'(obs_tag), 64'(k));
    end
    step('0, 1'b0);
    chk("t2_bcast_count", 64'(bus.bcast_count), 64'd5);

    // 3: units 1 and 3 with rr_ptr=2 -> 3, then 1, then 3
    do_reset('0);
    step(4'b0010, 1'b0);
    step(4'b1010, 1'b0);
    chk("t3_first_3", 64'(obs_ready), 64'b1000);
    step(4'b1010, 1'b0);
    chk("t3_then_1", 64'(obs_ready), 64'b0010);
    step(4'b1010, 1'b0);
    chk("t3_again_3", 64'(obs_ready), 64'b1000);
    step('0, 1'b0);

    // 4: grant to unit 1, flush next cycle suppresses broadcast and grants
    u_tag[1] = 4'h7;
    step(4'b0010, 1'b0);
    saved_cnt = bus.bcast_count;
    step('1, 1'b1);
    chk("t4_flush_ready", 64'(obs_ready), 64'd0);
    chk("t4_flush_valid", 64'(obs_valid), 64'd0);
    step('1, 1'b1);
    chk("t4_flush_hold_ready", 64'(obs_ready), 64'd0);
    step('0, 1'b0);
    chk("t4_count_unchanged", 64'(bus.bcast_count), 64'(saved_cnt));

    // 5: asynchronous reset with a broadcast pending
    step(4'b0001, 1'b0);
    #1;
    chk("t5_pending_valid", 64'(bus.cdb_valid), 64'd1);
    reset = 1'b0;
    #1;
    chk("t5_async_valid", 64'(bus.cdb_valid),   64'd0);
    chk("t5_async_tag",   64'(bus.cdb_tag),     64'd0);
    chk("t5_async_ready", 64'(bus.req_ready),   64'd0);
    chk("t5_async_count", 64'(bus.bcast_count), 64'd0);
    model_reset();
    bus.req_valid = '0;
    @(negedge clk);
    reset = 1'b1;
    step('1, 1'b0);
    chk("t5_rr_cleared", 64'(obs_ready), 64'b0001);
    step('0, 1'b0);

    // 6: mov unit wakes on tag 5 broadcast and forwards its data
    u_tag[2]  = 4'h1;
    u_data[2] = 32'h0;
    mov_req   = 1'b0;
    mov_data  = '0;
    step(4'b0100, 1'b0);
    u_tag[2]  = 4'h5;
    u_data[2] = 32'hDEAD_BEEF;
    step('0, 1'b0);
    if (obs_valid && obs_tag == 4'h5) begin
      mov_req  = 1'b1;
      mov_data = obs_data;
    end
    step({3'b000, mov_req}, 1'b0);
    chk("t6_mov_grant", 64'(obs_ready), 64'b0001);
    u_tag[0]  = 4'hA;
    u_data[0] = mov_data;
    step('0, 1'b0);
    chk("t6_mov_valid", 64'(obs_valid), 64'd1);
    chk("t6_mov_tag",   64'(obs_tag),   64'hA);
    chk("t6_mov_data",  64'(obs_data),  64'hDEAD_BEEF);

    // Randomised traffic against the model, with occasional flushes
    for (int c = 0; c < 200; c++) begin
      for (int i = 0; i < N; i++) begin
        u_tag[i]  = RW'($urandom);
        u_data[i] = DW'($urandom);
      end
      step(N'($urandom), ($urandom_range(0, 9) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
